// File: rtl/popcount20_unary_gen.sv
// Count-to-thermometer frame generator: held parallel vector plus N-beat serial stream.
// Optional macro UNARY_SCRAMBLE_EN permutes serial beat order with a per-frame seed.
module popcount20_unary_gen #(
   parameter int N  = 20,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_last,
   output logic [N-1:0]  out_vec,
   output logic          busy
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [CW-1:0] N_C    = CW'(N);
   localparam logic [CW-1:0] LAST_C = CW'(N - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

   state_t        state_r;
   logic [CW-1:0] beat_r;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] sat_count_s;
   logic [CW-1:0] beat_next_s;
   logic [CW-1:0] rank_next_s;
   logic [CW-1:0] first_rank_s;

   function automatic logic [N-1:0] therm(input logic [CW-1:0] c);
      logic [N-1:0] v;
      v = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         v[k] = (CW'(k) < c);
      end
      return v;
   endfunction

`ifdef UNARY_SCRAMBLE_EN
   localparam logic [CW:0] STEP_C = (CW+1)'(7 % N);
   localparam logic [CW:0] N_W    = (CW+1)'(N);

   logic [CW-1:0] rank_r;
   logic [CW-1:0] seed_r;
   logic [CW-1:0] seed_next_s;
   logic [CW:0]   rank_sum_s;

   // Next serial rank (7*i + seed) mod N, stepped incrementally, and next frame's seed.
   always_comb begin
      rank_sum_s = {1'b0, rank_r} + STEP_C;
      if (rank_sum_s >= N_W) begin
         rank_next_s = CW'(rank_sum_s - N_W);
      end else begin
         rank_next_s = rank_sum_s[CW-1:0];
      end
      if (seed_r == LAST_C) begin
         seed_next_s = ZERO_C;
      end else begin
         seed_next_s = seed_r + ONE_C;
      end
      first_rank_s = seed_r;
   end

   // Scramble rank and seed state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rank_r <= ZERO_C;
         seed_r <= ZERO_C;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  rank_r <= seed_r;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (beat_r == LAST_C) begin
                     seed_r <= seed_next_s;
                  end else begin
                     rank_r <= rank_next_s;
                  end
               end
            end
            default: begin
               rank_r <= ZERO_C;
            end
         endcase
      end
   end
`else
   // Plain thermometer order: the serial rank is the beat index itself.
   always_comb begin
      rank_next_s  = beat_r + ONE_C;
      first_rank_s = ZERO_C;
   end
`endif

   // Saturate the requested count and form the next beat index.
   always_comb begin
      if (in_count > N_C) begin
         sat_count_s = N_C;
      end else begin
         sat_count_s = in_count;
      end
      beat_next_s = beat_r + ONE_C;
   end

   // Frame FSM; every output is registered so reset clears them asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         beat_r    <= ZERO_C;
         cnt_r     <= ZERO_C;
         out_vec   <= {N{1'b0}};
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  cnt_r     <= sat_count_s;
                  beat_r    <= ZERO_C;
                  out_vec   <= therm(sat_count_s);
                  out_valid <= 1'b1;
                  out_bit   <= (first_rank_s < sat_count_s);
                  out_last  <= (LAST_C == ZERO_C);
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
                  state_r   <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (beat_r == LAST_C) begin
                     out_valid <= 1'b0;
                     out_bit   <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     state_r   <= IDLE;
                  end else begin
                     beat_r   <= beat_next_s;
                     out_bit  <= (rank_next_s < cnt_r);
                     out_last <= (beat_next_s == LAST_C);
                  end
               end
            end
            default: begin
               state_r   <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_popcount20_unary_gen.sv
// Scoreboard bench for popcount20_unary_gen: random counts and backpressure against an arithmetic frame model.
module tb_popcount20_unary_gen;
   localparam int N  = 20;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_count = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_bit;
   logic          out_last;
   logic [N-1:0]  out_vec;
   logic          busy;

   popcount20_unary_gen #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_last(out_last), .out_vec(out_vec), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   bit exp_q[$];
   logic [N-1:0] vec_q[$];
   int cnt_q[$];
   logic [N-1:0] last_vec = '0;
   int beat_pos = 0;
   int ones_acc = 0;
   int model_seed = 0;
   bit bp_mode = 1'b0;
   bit held_valid = 1'b0;
   logic held_bit, held_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: frame bit i is 1 when its rank is below the saturated count.
   function automatic void model_push(input int c);
      int sat;
      int r;
      logic [31:0] t;
      sat = (c > N) ? N : c;
      for (int i = 0; i < N; i++) begin
`ifdef UNARY_SCRAMBLE_EN
         r = (7 * i + model_seed) % N;
`else
         r = i;
`endif
         exp_q.push_back(r < sat);
      end
      t = (32'd1 << sat) - 32'd1;
      vec_q.push_back(t[N-1:0]);
      cnt_q.push_back(sat);
      model_seed = (model_seed + 1) % N;
   endfunction

   // Monitor: record accepted counts, compare every accepted beat, check stalls hold.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            chk("in_ready_low_in_frame", 32'(in_ready), 32'd0);
            chk("busy_in_frame", 32'(busy), 32'd1);
            if (held_valid) begin
               chk("stall_hold_bit", 32'(out_bit), 32'(held_bit));
               chk("stall_hold_last", 32'(out_last), 32'(held_last));
            end
            if (out_ready) begin
               held_valid = 1'b0;
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_beat: got bit %0d expected no beat", out_bit);
               end else begin
                  chk("beat_bit", 32'(out_bit), 32'(exp_q.pop_front()));
                  chk("beat_last", 32'(out_last), 32'(beat_pos == N - 1));
                  if (beat_pos == 0 && vec_q.size() > 0) begin
                     last_vec = vec_q.pop_front();
                     chk("out_vec", 32'(out_vec), 32'(last_vec));
                  end
                  ones_acc += int'(out_bit);
                  if (beat_pos == N - 1 && cnt_q.size() > 0) begin
                     chk("frame_ones", 32'(ones_acc), 32'(cnt_q.pop_front()));
                     ones_acc = 0;
                  end
                  beat_pos = (beat_pos + 1) % N;
               end
            end else begin
               held_valid = 1'b1;
               held_bit = out_bit;
               held_last = out_last;
            end
         end else begin
            held_valid = 1'b0;
         end
         if (in_valid && in_ready) model_push(int'(in_count));
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input int c);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_count = CW'(c);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      n_total++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && in_ready && !out_valid) begin
            chk("vec_held_idle", 32'(out_vec), 32'(last_vec));
            return;
         end
      end
      n_total++;
      $display("FAIL idle_timeout: got %0d beats pending expected 0", exp_q.size());
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_vec", 32'(out_vec), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

      send(13);
      for (k = 1; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (in_ready) break;
      end
      chk("frame_period", 32'(k + 1), 32'(N + 1));
      wait_idle();

      send(25);
      wait_idle();
      send(0);
      wait_idle();

      bp_mode = 1'b1;
      send(5);
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         #1;
         in_valid = 1'(j % 2);
         in_count = CW'($urandom_range(0, 31));
      end
      in_valid = 1'b0;
      wait_idle();
      bp_mode = 1'b0;

      send(10);
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (beat_pos >= 7) break;
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_vec", 32'(out_vec), 32'h0);
      chk("midrst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      vec_q.delete();
      cnt_q.delete();
      beat_pos = 0;
      ones_acc = 0;
      model_seed = 0;
      held_valid = 1'b0;
      last_vec = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(3);
      wait_idle();

      for (int c = 0; c <= N; c++) begin
         send(c);
         wait_idle();
      end
      bp_mode = 1'b1;
      for (int j = 0; j < 6; j++) begin
         send(int'($urandom_range(0, 31)));
         wait_idle();
      end
      bp_mode = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/popcount20_unary_gen.md
Name: popcount20_unary_gen

Overview:
- Inverse of the popcount20 reduction: takes a 5-bit count and produces a 20-bit unary (thermometer) frame containing exactly that many ones.
- Frame is output two ways: as a held parallel vector, and as a serial bitstream of 20 beats under valid/ready backpressure.
- Sits upstream of the popcount neurons: builds stimulus frames, and re-encodes neuron activations for the next ternary layer.

Parameters:
- N, 20, frame length in bits (beats per frame).
- CW, 5, count width; must satisfy 2^CW > N.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_count is valid.
- in_ready  output  1  block can accept a count.
- in_count  input  CW  requested number of ones.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  consumer accepts out_bit.
- out_bit  output  1  current serial beat.
- out_last  output  1  marks beat N-1 of the frame.
- out_vec  output  N  parallel thermometer vector of the last accepted count, held.
- busy  output  1  frame emission in progress.

Behaviour:
- Reset (async assert, sync release) forces all of the following to 0: state, beat counter, stored count, out_vec, out_valid, out_bit, out_last, busy.
- in_ready=1 immediately after reset.
- FSM has 2 states: IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid&&in_ready, the block latches cnt_q = min(in_count, N) (saturating), sets beat index i=0, and moves to EMIT.
  - Also on that acceptance, out_vec <= (1<<cnt_q)-1, so bits [cnt_q-1:0]=1. out_vec updates only on acceptance.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_bit = (i < cnt_q); out_last = (i == N-1).
  - On out_valid&&out_ready, i increments.
  - On the beat where out_last is set and is accepted, the FSM returns to IDLE and in_ready=1 on the next cycle.
  - There is no overlap between frames: the minimum frame period is N+1 cycles.
- Latency: count accepted at cycle t gives first beat valid at t+1 and out_vec valid at t+1.
- Backpressure: while out_valid=1 and out_ready=0, out_bit, out_last and i are held stable. There is no timeout.
- Boundary cases:
  - in_count=0 emits N zeros with out_last on the final beat (a frame is always N beats).
  - in_count>=N emits N ones.
  - in_valid while busy is ignored; the source must hold it.
- Reset mid-frame aborts the frame immediately: out_valid drops asynchronously and out_vec clears. No partial-frame completion.
- Invariant: the ones in each serial frame equal popcount(out_vec) = cnt_q.

Optional Feature:
- Macro: UNARY_SCRAMBLE_EN.
- Defined:
  - The serial ordering is permuted: out_bit = (r_i < cnt_q), where r_i = (7*i + seed) mod N, computed incrementally (r_0 = seed; r_{i+1} = r_i+7, subtracting N on overflow).
  - seed is a 5-bit register, reset to 0, incremented mod N on each frame's last accepted beat.
  - Since gcd(7,20)=1, r_i is a permutation, so the ones count is still exactly cnt_q.
  - out_vec stays thermometer (unscrambled).
- Undefined: r_i = i, the plain thermometer order (ones first). No seed register is present.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> out_vec=0x00000, out_valid=0, in_ready=1, busy=0.
- Count 13, out_ready=1: in_count=13 -> beats 0..12 are 1 and 13..19 are 0; out_last only on beat 19; out_vec=0x01FFF; in_ready high again 21 cycles after acceptance.
- Saturation and zero: in_count=25 -> 20 ones, out_vec=0xFFFFF; then in_count=0 -> 20 zeros, out_vec=0x00000, out_last still on beat 19.
- Backpressure: in_count=5 with out_ready toggled pseudo-randomly (about 50%) -> each beat is held stable while stalled, exactly 5 ones in 20 accepted beats, and in_valid pulses during the frame are not accepted.
- Reset mid-frame: assert rst_n=0 at beat 7 of a count-10 frame -> out_valid=0 and out_vec=0 with no clock edge; after release, a new count-3 frame emits correctly.
- UNARY_SCRAMBLE_EN: first frame after reset, count 4 -> ones at beats where (7i mod 20)<4, i.e. beats 0, 3, 6, 9; second frame uses seed=1; every frame has ones count equal to cnt_q for counts 0..20.
